ysyx_23060077_riscv_arbiter: RTL and testbench

Two-master memory arbiter between the core's fetch path (IFU, read-only) and load/store path (LSU, read/write) and a single AXI4-Lite slave port toward memory/peripherals. It grants one master, runs exactly one AXI4-Lite transaction, and returns a one-cycle response pulse to the granted master. It is non-pipelined: one outstanding transaction total.

---
 rtl/ysyx_23060077_riscv_arbiter.sv | 224 ++++++++++++++++++++++
 tb/tb_ysyx_23060077_riscv_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060077_riscv_arbiter.sv
// Two-master (IFU read-only, LSU read/write) arbiter in front of a single
// AXI4-Lite slave port. One transaction in flight at a time; the granted
// master gets a one-cycle response pulse with registered rdata/err.
// Optional feature macro: ARB_ROUND_ROBIN_EN (round-robin tie-break instead
// of fixed LSU-over-IFU priority).
module ysyx_23060077_riscv_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // IFU
    input  logic                  ifu_req_valid_i,
    output logic                  ifu_req_ready_o,
    input  logic [ADDR_WIDTH-1:0] ifu_addr_i,
    output logic                  ifu_rsp_valid_o,
    output logic [DATA_WIDTH-1:0] ifu_rdata_o,
    output logic                  ifu_rsp_err_o,
    // LSU
    input  logic                  lsu_req_valid_i,
    output logic                  lsu_req_ready_o,
    input  logic [ADDR_WIDTH-1:0] lsu_addr_i,
    input  logic                  lsu_wen_i,
    input  logic [DATA_WIDTH-1:0] lsu_wdata_i,
    input  logic [STRB_WIDTH-1:0] lsu_wstrb_i,
    output logic                  lsu_rsp_valid_o,
    output logic [DATA_WIDTH-1:0] lsu_rdata_o,
    output logic                  lsu_rsp_err_o,
    // AXI4-Lite read address / data
    output logic [ADDR_WIDTH-1:0] axi_araddr_o,
    output logic                  axi_arvalid_o,
    input  logic                  axi_arready_i,
    input  logic [DATA_WIDTH-1:0] axi_rdata_i,
    input  logic [1:0]            axi_rresp_i,
    input  logic                  axi_rvalid_i,
    output logic                  axi_rready_o,
    // AXI4-Lite write address / data / response
    output logic [ADDR_WIDTH-1:0] axi_awaddr_o,
    output logic                  axi_awvalid_o,
    input  logic                  axi_awready_i,
    output logic [DATA_WIDTH-1:0] axi_wdata_o,
    output logic [STRB_WIDTH-1:0] axi_wstrb_o,
    output logic                  axi_wvalid_o,
    input  logic                  axi_wready_i,
    input  logic [1:0]            axi_bresp_i,
    input  logic                  axi_bvalid_i,
    output logic                  axi_bready_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_RD_ADDR, S_RD_DATA, S_WR_ADDR, S_WR_RESP, S_RESP
    } state_e;

    state_e                state_q;
    logic                  owner_lsu_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_WIDTH-1:0] wstrb_q;
    logic                  arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q;
    logic                  aw_done_q, w_done_q;
    logic                  ifu_rsp_valid_q, lsu_rsp_valid_q;
    logic [DATA_WIDTH-1:0] ifu_rdata_q, lsu_rdata_q;
    logic                  ifu_err_q, lsu_err_q;

    logic gnt_lsu, gnt_ifu;
    logic aw_fire, w_fire;

`ifdef ARB_ROUND_ROBIN_EN
    // 1 = LSU was granted last; reset to LSU so IFU wins the first tie
    logic last_lsu_q;

    // Tie goes to whoever was not granted last; a lone requester always wins
    always_comb begin
        gnt_lsu = lsu_req_valid_i;
        if (lsu_req_valid_i && ifu_req_valid_i)
            gnt_lsu = !last_lsu_q;
    end

    // Remember the winner of every request handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_lsu_q <= 1'b1;
        else if (ifu_req_ready_o || lsu_req_ready_o)
            last_lsu_q <= lsu_req_ready_o;
    end
`else
    // Fixed priority: LSU beats IFU
    always_comb begin
        gnt_lsu = lsu_req_valid_i;
    end
`endif

    assign gnt_ifu         = ifu_req_valid_i && !gnt_lsu;
    assign ifu_req_ready_o = (state_q == S_IDLE) && gnt_ifu;
    assign lsu_req_ready_o = (state_q == S_IDLE) && gnt_lsu;

    assign aw_fire = awvalid_q && axi_awready_i;
    assign w_fire  = wvalid_q && axi_wready_i;

    // Idle channels present zero payload; payload is held from registers
    // so it stays stable while valid waits for ready.
    assign axi_araddr_o  = arvalid_q ? addr_q : '0;
    assign axi_arvalid_o = arvalid_q;
    assign axi_rready_o  = rready_q;
    assign axi_awaddr_o  = awvalid_q ? addr_q : '0;
    assign axi_awvalid_o = awvalid_q;
    assign axi_wdata_o   = wvalid_q ? wdata_q : '0;
    assign axi_wstrb_o   = wvalid_q ? wstrb_q : '0;
    assign axi_wvalid_o  = wvalid_q;
    assign axi_bready_o  = bready_q;

    assign ifu_rsp_valid_o = ifu_rsp_valid_q;
    assign ifu_rdata_o     = ifu_rdata_q;
    assign ifu_rsp_err_o   = ifu_err_q;
    assign lsu_rsp_valid_o = lsu_rsp_valid_q;
    assign lsu_rdata_o     = lsu_rdata_q;
    assign lsu_rsp_err_o   = lsu_err_q;

    // Transaction FSM with registered AXI handshake signals and responses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            owner_lsu_q     <= 1'b0;
            addr_q          <= '0;
            wdata_q         <= '0;
            wstrb_q         <= '0;
            arvalid_q       <= 1'b0;
            rready_q        <= 1'b0;
            awvalid_q       <= 1'b0;
            wvalid_q        <= 1'b0;
            bready_q        <= 1'b0;
            aw_done_q       <= 1'b0;
            w_done_q        <= 1'b0;
            ifu_rsp_valid_q <= 1'b0;
            lsu_rsp_valid_q <= 1'b0;
            ifu_rdata_q     <= '0;
            lsu_rdata_q     <= '0;
            ifu_err_q       <= 1'b0;
            lsu_err_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (lsu_req_ready_o) begin
                        owner_lsu_q <= 1'b1;
                        addr_q      <= lsu_addr_i;
                        wdata_q     <= lsu_wdata_i;
                        wstrb_q     <= lsu_wstrb_i;
                        if (lsu_wen_i) begin
                            state_q   <= S_WR_ADDR;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                        end else begin
                            state_q   <= S_RD_ADDR;
                            arvalid_q <= 1'b1;
                        end
                    end else if (ifu_req_ready_o) begin
                        owner_lsu_q <= 1'b0;
                        addr_q      <= ifu_addr_i;
                        wdata_q     <= '0;
                        wstrb_q     <= '0;
                        state_q     <= S_RD_ADDR;
                        arvalid_q   <= 1'b1;
                    end
                end
                S_RD_ADDR: begin
                    if (axi_arready_i) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= S_RD_DATA;
                    end
                end
                S_RD_DATA: begin
                    if (axi_rvalid_i) begin
                        rready_q <= 1'b0;
                        state_q  <= S_RESP;
                        if (owner_lsu_q) begin
                            lsu_rdata_q     <= axi_rdata_i;
                            lsu_err_q       <= |axi_rresp_i;
                            lsu_rsp_valid_q <= 1'b1;
                        end else begin
                            ifu_rdata_q     <= axi_rdata_i;
                            ifu_err_q       <= |axi_rresp_i;
                            ifu_rsp_valid_q <= 1'b1;
                        end
                    end
                end
                S_WR_ADDR: begin
                    // AW and W retire independently; leave once both are done
                    if (aw_fire) begin
                        awvalid_q <= 1'b0;
                        aw_done_q <= 1'b1;
                    end
                    if (w_fire) begin
                        wvalid_q <= 1'b0;
                        w_done_q <= 1'b1;
                    end
                    if ((aw_done_q || aw_fire) && (w_done_q || w_fire)) begin
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                        bready_q  <= 1'b1;
                        state_q   <= S_WR_RESP;
                    end
                end
                S_WR_RESP: begin
                    if (axi_bvalid_i) begin
                        bready_q        <= 1'b0;
                        lsu_rdata_q     <= '0;
                        lsu_err_q       <= |axi_bresp_i;
                        lsu_rsp_valid_q <= 1'b1;
                        state_q         <= S_RESP;
                    end
                end
                S_RESP: begin
                    ifu_rsp_valid_q <= 1'b0;
                    lsu_rsp_valid_q <= 1'b0;
                    state_q         <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_23060077_riscv_arbiter.sv
// Directed bench for ysyx_23060077_riscv_arbiter: behavioural AXI4-Lite slave
// with per-channel wait counts, request drivers for both masters, and a
// monitor that records handshake/response cycles.
module tb_ysyx_23060077_riscv_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_err;
    logic [31:0] ifu_addr, ifu_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_rsp_valid, lsu_rsp_err;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [3:0]  lsu_wstrb;
    logic [31:0] axi_araddr, axi_rdata, axi_awaddr, axi_wdata;
    logic        axi_arvalid, axi_arready, axi_rvalid, axi_rready;
    logic        axi_awvalid, axi_awready, axi_wvalid, axi_wready, axi_bvalid, axi_bready;
    logic [1:0]  axi_rresp, axi_bresp;
    logic [3:0]  axi_wstrb;

    always #5 clk = ~clk;

    ysyx_23060077_riscv_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .ifu_req_valid_i(ifu_req_valid), .ifu_req_ready_o(ifu_req_ready),
        .ifu_addr_i(ifu_addr), .ifu_rsp_valid_o(ifu_rsp_valid),
        .ifu_rdata_o(ifu_rdata), .ifu_rsp_err_o(ifu_rsp_err),
        .lsu_req_valid_i(lsu_req_valid), .lsu_req_ready_o(lsu_req_ready),
        .lsu_addr_i(lsu_addr), .lsu_wen_i(lsu_wen), .lsu_wdata_i(lsu_wdata),
        .lsu_wstrb_i(lsu_wstrb), .lsu_rsp_valid_o(lsu_rsp_valid),
        .lsu_rdata_o(lsu_rdata), .lsu_rsp_err_o(lsu_rsp_err),
        .axi_araddr_o(axi_araddr), .axi_arvalid_o(axi_arvalid), .axi_arready_i(axi_arready),
        .axi_rdata_i(axi_rdata), .axi_rresp_i(axi_rresp), .axi_rvalid_i(axi_rvalid),
        .axi_rready_o(axi_rready),
        .axi_awaddr_o(axi_awaddr), .axi_awvalid_o(axi_awvalid), .axi_awready_i(axi_awready),
        .axi_wdata_o(axi_wdata), .axi_wstrb_o(axi_wstrb), .axi_wvalid_o(axi_wvalid),
        .axi_wready_i(axi_wready),
        .axi_bresp_i(axi_bresp), .axi_bvalid_i(axi_bvalid), .axi_bready_o(axi_bready)
    );

    // Written only by the stimulus process
    int          ifu_req_n = 0, lsu_req_n = 0;
    logic [31:0] ifu_a = '0, lsu_a = '0, lsu_wd = '0, s_rdata = '0;
    logic        lsu_w = 1'b0;
    logic [3:0]  lsu_ws = '0;
    logic [1:0]  s_rresp = '0, s_bresp = '0;
    int          ar_wait = 0, aw_wait = 0, w_wait = 0, r_wait = 0, b_wait = 0;

    // Written only by the slave/monitor process
    int          cyc = 0, ifu_hs_n = 0, lsu_hs_n = 0;
    int          ar_cnt = 0, aw_cnt = 0, w_cnt = 0, r_cnt = 0, b_cnt = 0;
    bit          rd_pend = 0, b_pend = 0, aw_got = 0, w_got = 0;
    logic [31:0] got_araddr = '0, got_awaddr = '0, got_wdata = '0;
    logic [3:0]  got_wstrb = '0;
    int          aw_hi = 0, w_hi = 0;
    int          ifu_rsp_cnt = 0, lsu_rsp_cnt = 0;
    int          ifu_hs_cyc = 0, lsu_hs_cyc = 0, ifu_rsp_cyc = 0, lsu_rsp_cyc = 0;
    int          gq[$];

    int checks = 0, errors = 0;

    // Slave, master drivers and monitor all act on the falling edge
    always @(negedge clk) begin
        cyc++;
        axi_rdata = s_rdata;
        axi_rresp = s_rresp;
        axi_bresp = s_bresp;
        if (!rst_n) begin
            rd_pend = 0; b_pend = 0; aw_got = 0; w_got = 0;
            ar_cnt = 0; aw_cnt = 0; w_cnt = 0; r_cnt = 0; b_cnt = 0;
            axi_arready = 0; axi_rvalid = 0; axi_awready = 0; axi_wready = 0; axi_bvalid = 0;
        end else begin
            if (rd_pend) begin
                axi_rvalid = (r_cnt >= r_wait); r_cnt++;
                if (axi_rvalid && axi_rready) rd_pend = 0;
            end else axi_rvalid = 0;
            if (b_pend) begin
                axi_bvalid = (b_cnt >= b_wait); b_cnt++;
                if (axi_bvalid && axi_bready) b_pend = 0;
            end else axi_bvalid = 0;
            if (axi_arvalid) begin
                axi_arready = (ar_cnt >= ar_wait); ar_cnt++;
                if (axi_arready) begin rd_pend = 1; r_cnt = 0; ar_cnt = 0; got_araddr = axi_araddr; end
            end else begin axi_arready = 0; ar_cnt = 0; end
            if (axi_awvalid) begin
                aw_hi++;
                axi_awready = (aw_cnt >= aw_wait); aw_cnt++;
                if (axi_awready) begin aw_got = 1; aw_cnt = 0; got_awaddr = axi_awaddr; end
            end else begin axi_awready = 0; aw_cnt = 0; end
            if (axi_wvalid) begin
                w_hi++;
                axi_wready = (w_cnt >= w_wait); w_cnt++;
                if (axi_wready) begin w_got = 1; w_cnt = 0; got_wdata = axi_wdata; got_wstrb = axi_wstrb; end
            end else begin axi_wready = 0; w_cnt = 0; end
            if (aw_got && w_got) begin b_pend = 1; b_cnt = 0; aw_got = 0; w_got = 0; end
        end
        ifu_req_valid = (ifu_req_n > ifu_hs_n);
        ifu_addr      = ifu_a;
        lsu_req_valid = (lsu_req_n > lsu_hs_n);
        lsu_addr      = lsu_a;
        lsu_wen       = lsu_w;
        lsu_wdata     = lsu_wd;
        lsu_wstrb     = lsu_ws;
        #1;
        if (ifu_req_valid && ifu_req_ready) begin gq.push_back(0); ifu_hs_cyc = cyc; ifu_hs_n++; end
        if (lsu_req_valid && lsu_req_ready) begin gq.push_back(1); lsu_hs_cyc = cyc; lsu_hs_n++; end
        if (ifu_rsp_valid) begin ifu_rsp_cnt++; ifu_rsp_cyc = cyc; end
        if (lsu_rsp_valid) begin lsu_rsp_cnt++; lsu_rsp_cyc = cyc; end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_ifu(input int n);
        for (int i = 0; i < 100 && ifu_rsp_cnt < n; i++) tick();
        chk("ifu_rsp_count", ifu_rsp_cnt, n);
    endtask

    task automatic wait_lsu(input int n);
        for (int i = 0; i < 100 && lsu_rsp_cnt < n; i++) tick();
        chk("lsu_rsp_count", lsu_rsp_cnt, n);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        int base_i, base_l, gbase, aw0, w0;
        axi_arready = 0; axi_rvalid = 0; axi_awready = 0; axi_wready = 0; axi_bvalid = 0;
        axi_rdata = '0; axi_rresp = '0; axi_bresp = '0;
        ifu_req_valid = 0; lsu_req_valid = 0; ifu_addr = '0; lsu_addr = '0;
        lsu_wen = 0; lsu_wdata = '0; lsu_wstrb = '0;

        // Reset state
        repeat (3) tick();
        chk("rst_arvalid", axi_arvalid, 0);
        chk("rst_rready", axi_rready, 0);
        chk("rst_awvalid", axi_awvalid, 0);
        chk("rst_wvalid", axi_wvalid, 0);
        chk("rst_bready", axi_bready, 0);
        chk("rst_ifu_rsp", ifu_rsp_valid, 0);
        chk("rst_lsu_rsp", lsu_rsp_valid, 0);
        chk("rst_ifu_rdata", ifu_rdata, 0);
        chk("rst_lsu_err", lsu_rsp_err, 0);
        chk("rst_araddr", axi_araddr, 0);
        rst_n = 1'b1;
        tick();

        // IFU read, zero-wait slave
        s_rdata = 32'h0000_0413; s_rresp = 2'b00;
        ifu_a = 32'h8000_0000; ifu_req_n++;
        wait_ifu(1);
        chk("ifu_rd_latency", ifu_rsp_cyc - ifu_hs_cyc, 3);
        chk("ifu_rd_rdata", ifu_rdata, 32'h0000_0413);
        chk("ifu_rd_err", ifu_rsp_err, 0);
        chk("ifu_rd_araddr", got_araddr, 32'h8000_0000);
        chk("ifu_rd_no_lsu_rsp", lsu_rsp_cnt, 0);
        repeat (3) tick();
        chk("ifu_rsp_one_cycle", ifu_rsp_cnt, 1);

        // LSU read with error, then a clean read
        s_rdata = 32'hCAFE_0001; s_rresp = 2'b10;
        lsu_a = 32'h8000_2000; lsu_w = 1'b0; lsu_req_n++;
        wait_lsu(1);
        chk("lsu_rd_err", lsu_rsp_err, 1);
        chk("lsu_rd_err_rdata", lsu_rdata, 32'hCAFE_0001);
        chk("lsu_rd_ifu_err_held", ifu_rsp_err, 0);
        s_rdata = 32'h1234_5678; s_rresp = 2'b00;
        lsu_req_n++;
        wait_lsu(2);
        chk("lsu_rd_err_clear", lsu_rsp_err, 0);
        chk("lsu_rd_rdata", lsu_rdata, 32'h1234_5678);
        chk("lsu_rd_ifu_rdata_held", ifu_rdata, 32'h0000_0413);

        // LSU write, AW delayed by 2 wait cycles, W immediate
        aw_wait = 2; s_bresp = 2'b00;
        lsu_a = 32'h8000_1000; lsu_wd = 32'hDEAD_BEEF; lsu_ws = 4'hF; lsu_w = 1'b1;
        aw0 = aw_hi; w0 = w_hi;
        lsu_req_n++;
        wait_lsu(3);
        chk("wr_awvalid_cycles", aw_hi - aw0, 3);
        chk("wr_wvalid_cycles", w_hi - w0, 1);
        chk("wr_awaddr", got_awaddr, 32'h8000_1000);
        chk("wr_wdata", got_wdata, 32'hDEAD_BEEF);
        chk("wr_wstrb", got_wstrb, 4'hF);
        chk("wr_latency", lsu_rsp_cyc - lsu_hs_cyc, 5);
        chk("wr_rdata_zero", lsu_rdata, 0);
        chk("wr_err", lsu_rsp_err, 0);

        // Zero-wait write with bad bresp
        aw_wait = 0; s_bresp = 2'b10;
        lsu_a = 32'h8000_1004; lsu_ws = 4'h3;
        lsu_req_n++;
        wait_lsu(4);
        chk("wr_err_latency", lsu_rsp_cyc - lsu_hs_cyc, 3);
        chk("wr_bresp_err", lsu_rsp_err, 1);
        chk("wr_partial_wstrb", got_wstrb, 4'h3);
        s_bresp = 2'b00; lsu_w = 1'b0;

        // Simultaneous requests
        do_reset();
        s_rdata = 32'h0000_0001;
        ifu_a = 32'h8000_0010; lsu_a = 32'h8000_3000;
        base_i = ifu_rsp_cnt; base_l = lsu_rsp_cnt; gbase = gq.size();
`ifdef ARB_ROUND_ROBIN_EN
        ifu_req_n += 2; lsu_req_n += 2;
        wait_ifu(base_i + 2);
        wait_lsu(base_l + 2);
        chk("rr_grant_count", gq.size() - gbase, 4);
        if (gq.size() - gbase >= 4) begin
            chk("rr_grant0", gq[gbase], 0);
            chk("rr_grant1", gq[gbase + 1], 1);
            chk("rr_grant2", gq[gbase + 2], 0);
            chk("rr_grant3", gq[gbase + 3], 1);
        end
`else
        ifu_req_n++; lsu_req_n++;
        wait_ifu(base_i + 1);
        chk("prio_lsu_served", lsu_rsp_cnt, base_l + 1);
        chk("prio_grant_count", gq.size() - gbase, 2);
        if (gq.size() - gbase >= 2) begin
            chk("prio_first_lsu", gq[gbase], 1);
            chk("prio_second_ifu", gq[gbase + 1], 0);
        end
        chk("prio_ifu_after_rsp", ifu_hs_cyc - lsu_rsp_cyc, 1);
`endif

        // Reset while waiting in RD_DATA
        r_wait = 5;
        base_i = ifu_rsp_cnt;
        ifu_a = 32'h8000_0020; ifu_req_n++;
        for (int i = 0; i < 20 && !axi_rready; i++) tick();
        chk("abort_reached_rd_data", axi_rready, 1);
        tick();
        rst_n = 1'b0;
        #1;
        chk("abort_rready", axi_rready, 0);
        chk("abort_arvalid", axi_arvalid, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (10) tick();
        chk("abort_no_rsp", ifu_rsp_cnt, base_i);
        r_wait = 0; s_rdata = 32'h0010_0093;
        ifu_a = 32'h8000_0004; ifu_req_n++;
        wait_ifu(base_i + 1);
        chk("post_abort_latency", ifu_rsp_cyc - ifu_hs_cyc, 3);
        chk("post_abort_rdata", ifu_rdata, 32'h0010_0093);
        chk("post_abort_araddr", got_araddr, 32'h8000_0004);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
